// File: rtl/dlfloat_pkg.sv
// Shared DLfloat16 definitions: format widths, well-known constants and the
// operand-pair type carried between host-side blocks.
package dlfloat_pkg;

  localparam int DLF_W     = 16;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_BIAS  = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;

  // Bus slot currently being driven to the MAC wrapper.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } bus_phase_e;

  function automatic logic dlf_is_nan(input logic [DLF_W-1:0] v);
    return v == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// Small synchronous FIFO of DLfloat16 operand pairs with flush.
// Head is read straight from the array so a pop can launch the pair on the same edge.
module dlfloat_pair_fifo
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  dlf_pair_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output dlf_pair_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  dlf_pair_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == '0);
  assign level = level_reg;
  assign head  = mem[rd_ptr_reg];

  // Flush wins over both operations; the pointers wrap naturally at DEPTH.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/dlfloat_operand_tx.sv
// Host-side transmitter for the MAC's two-phase operand bus: queues (A,B) pairs
// and drives A then B into free-running alternating slots, with zero bubbles when idle.
module dlfloat_operand_tx
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DLF_W-1:0]       in_a,
  input  logic [DLF_W-1:0]       in_b,
  input  logic                   flush,
  output logic [DLF_W-1:0]       bus_out,
  output logic                   phase_out,
  output logic                   pair_sent,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       sent_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  bus_phase_e       phase_reg;
  logic [DLF_W-1:0] bus_reg;
  logic [DLF_W-1:0] b_hold_reg;
  logic             pair_sent_reg;
  logic [CNT_W-1:0] sent_cnt_reg;

  dlf_pair_t        push_data;
  dlf_pair_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop_slot;
  logic             launch;

  assign in_ready  = !fifo_full && !flush;
  assign push      = in_valid && in_ready;
  assign push_data = '{a: in_a, b: in_b};

  // Pops happen only on the edge that opens an A slot, so a pair always
  // occupies an adjacent A/B slot couple and can never be split.
  assign pop_slot = (phase_reg == PH_B);
  assign launch   = pop_slot && !fifo_empty && !flush;

  dlfloat_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop_slot),
    .flush    (flush),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg     <= PH_A;
      bus_reg       <= DLF_ZERO;
      b_hold_reg    <= DLF_ZERO;
      pair_sent_reg <= 1'b0;
      sent_cnt_reg  <= '0;
    end else begin
      case (phase_reg)
        PH_A: begin
          // B slot always replays the held operand, even across a flush.
          phase_reg     <= PH_B;
          bus_reg       <= b_hold_reg;
          pair_sent_reg <= 1'b0;
        end
        default: begin
          phase_reg <= PH_A;
          if (launch) begin
            bus_reg       <= head.a;
            b_hold_reg    <= head.b;
            pair_sent_reg <= 1'b1;
            sent_cnt_reg  <= sent_cnt_reg + CNT_ONE;
          end else begin
            bus_reg       <= DLF_ZERO;
            b_hold_reg    <= DLF_ZERO;
            pair_sent_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus_out   = bus_reg;
  assign phase_out = phase_reg;
  assign pair_sent = pair_sent_reg;
  assign sent_cnt  = sent_cnt_reg;

endmodule
